parking_gate_sensor: RTL
========================

Name: parking_gate_sensor

Overview:
- Front-end that produces the single-cycle `entry_button` / `exit_button` events consumed by the lot occupancy counter.
- Watches two raw light-beam sensors in the gate lane: A on the street side, B on the lot side.
- Synchronizes and debounces both beams, then tracks the A/B sequence to decide direction.
- Emits exactly one entry or exit pulse per completed car transit; refuses entry while the lot is full.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized beam must hold a new value before the debounced value changes (>=1).
- TIMEOUT_CYCLES, 1000: maximum cycles a transit may take after leaving IDLE before it is aborted (>=2).
- TMO_W, 16: width of the transit timeout counter; 2**TMO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- beam_a_raw  in  1  asynchronous street-side beam; 1 = blocked.
- beam_b_raw  in  1  asynchronous lot-side beam; 1 = blocked.
- lot_full  in  1  lot full indication from the occupancy counter (its full LED signal).
- entry_pulse  out  1  one-cycle pulse per completed entry; drives the counter's entry_button.
- exit_pulse  out  1  one-cycle pulse per completed exit; drives the counter's exit_button.
- gate_open  out  1  high while a valid transit is in progress.
- deny_pulse  out  1  one-cycle pulse when an entry attempt is refused because the lot is full.
- fault_pulse  out  1  one-cycle pulse on an illegal beam pattern or a timeout.

Behaviour:
- Reset (synchronous, active-high), applies at any time including mid-transit:
  - sync flops, debounced a/b, debounce counters and timeout counter all clear to 0.
  - state goes to IDLE.
  - all outputs are 0 in the cycle after the reset edge.
  - no pulse is emitted because of reset.
- Synchronizer: 2-flop chain per beam.
- Debounce, per beam:
  - the counter increments on each edge where the synchronized value differs from the debounced value, and clears when they match.
  - on the edge where the counter would reach DEBOUNCE_CYCLES, the debounced value flips and the counter clears.
  - a glitch shorter than DEBOUNCE_CYCLES cycles is never seen.
- FSM states: IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A, WAIT_CLEAR. All inputs are the debounced a,b.
- IDLE:
  - a&!b: if lot_full, go to WAIT_CLEAR and pulse deny; else go to IN_A.
  - !a&b: go to OUT_B.
  - a&b: go to WAIT_CLEAR and pulse fault.
- IN_A:
  - a&b: go to IN_AB.
  - !a&!b: go to IDLE (car backed out; no pulse).
  - !a&b: go to WAIT_CLEAR and pulse fault.
- IN_AB:
  - !a&b: go to IN_B.
  - a&!b: go to IN_A.
  - !a&!b: go to IDLE with no pulse.
- IN_B:
  - !a&!b: go to IDLE and pulse entry.
  - a&b: go to IN_AB.
  - a&!b: go to WAIT_CLEAR and pulse fault.
- OUT_B, OUT_AB, OUT_A mirror IN_A, IN_AB, IN_B with a and b swapped. The completion from OUT_A pulses exit. lot_full is ignored for exits.
- WAIT_CLEAR: stay until !a&!b, then go to IDLE. No pulses are issued from here.
- Timeout counter:
  - clears in IDLE and WAIT_CLEAR; increments every cycle in IN_*/OUT_*.
  - on reaching TIMEOUT_CYCLES: go to WAIT_CLEAR and pulse fault. This takes priority over a same-cycle beam transition.
- Every pulse output is registered and set on the same edge as the causing state transition. Each is high for exactly 1 cycle; back-to-back pulses on the same output are impossible.
- gate_open = registered state is one of IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A.
- lot_full is sampled only in IDLE on an a&!b entry start. If lot_full rises mid-transit, the entry still completes and pulses. The counter's own saturation absorbs it.
- Latency: a raw beam change that is held stable reaches the FSM after 2+DEBOUNCE_CYCLES edges. The resulting pulse is high after DEBOUNCE_CYCLES+3 edges (7 with the default).
- At most one of entry/exit/deny/fault pulses is high in any cycle.

Test Plan:
- Each sequence step below is held 10 cycles, DEBOUNCE_CYCLES=4.
1. Reset, then entry sequence A=1,B=0 -> A=1,B=1 -> A=0,B=1 -> A=0,B=0 with lot_full=0 -> gate_open high from IN_A onward; exactly one entry_pulse, 7 cycles after the final clear; exit/deny/fault stay 0.
2. Exit sequence B -> AB -> A -> clear -> exactly one exit_pulse; entry_pulse stays 0.
3. lot_full=1, then A=1 -> deny_pulse once, gate_open stays 0, no entry_pulse; the FSM returns to IDLE after A drops.
4. A toggles 3-cycle glitches on beam A in IDLE -> no state change, all outputs 0. Then A held, AB, back to A, clear (car reverses) -> no pulses, FSM in IDLE.
5. TIMEOUT_CYCLES=50; A=1 held for 80 cycles -> fault_pulse once, 50 cycles after IN_A entry; gate_open drops; no entry_pulse after A clears.
6. Reset asserted for 1 cycle while in IN_AB -> next cycle all outputs 0, state IDLE. A subsequent B-only then clear produces no entry_pulse and no exit_pulse (incomplete sequence from OUT_B).

Source files
------------

// File: rtl/parking_gate_sensor.sv
// Gate-lane beam front-end: synchronizes and debounces the street (A) and lot (B)
// beams, tracks the A/B order and emits one entry/exit/deny/fault pulse per event.
module parking_gate_sensor #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1000,
    parameter int unsigned TMO_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic beam_a_raw,
    input  logic beam_b_raw,
    input  logic lot_full,
    output logic entry_pulse,
    output logic exit_pulse,
    output logic gate_open,
    output logic deny_pulse,
    output logic fault_pulse
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A, WAIT_CLEAR
    } state_t;

    // bit 0 = beam A, bit 1 = beam B
    logic [1:0]      sync1, sync2, db;
    logic [DB_W-1:0] db_cnt [2];
    logic [TMO_W-1:0] tmo;
    logic [1:0]      ab;
    state_t          state;

    // 2-flop synchronizer then per-beam debounce counter
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            db        <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1 <= {beam_b_raw, beam_a_raw};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // {a, b}: 2'b10 = street beam only, 2'b01 = lot beam only
    assign ab = {db[0], db[1]};

    // Direction FSM; gate_open tracks whether the next state is a transit state
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tmo         <= '0;
            entry_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
            deny_pulse  <= 1'b0;
            fault_pulse <= 1'b0;
            gate_open   <= 1'b0;
        end else begin
            entry_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
            deny_pulse  <= 1'b0;
            fault_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    tmo <= '0;
                    case (ab)
                        2'b10: begin
                            if (lot_full) begin
                                state      <= WAIT_CLEAR;
                                deny_pulse <= 1'b1;
                            end else begin
                                state     <= IN_A;
                                gate_open <= 1'b1;
                            end
                        end
                        2'b01: begin
                            state     <= OUT_B;
                            gate_open <= 1'b1;
                        end
                        2'b11: begin
                            state       <= WAIT_CLEAR;
                            fault_pulse <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                WAIT_CLEAR: begin
                    tmo <= '0;
                    if (ab == 2'b00) state <= IDLE;
                end
                default: begin
                    // timeout wins over any beam change in the same cycle
                    if (tmo == TMO_LAST) begin
                        state       <= WAIT_CLEAR;
                        fault_pulse <= 1'b1;
                        gate_open   <= 1'b0;
                        tmo         <= '0;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                        case (state)
                            IN_A: case (ab)
                                2'b11: state <= IN_AB;
                                2'b00: begin state <= IDLE; gate_open <= 1'b0; end
                                2'b01: begin
                                    state <= WAIT_CLEAR; fault_pulse <= 1'b1; gate_open <= 1'b0;
                                end
                                default: ;
                            endcase
                            IN_AB: case (ab)
                                2'b01: state <= IN_B;
                                2'b10: state <= IN_A;
                                2'b00: begin state <= IDLE; gate_open <= 1'b0; end
                                default: ;
                            endcase
                            IN_B: case (ab)
                                2'b00: begin
                                    state <= IDLE; entry_pulse <= 1'b1; gate_open <= 1'b0;
                                end
                                2'b11: state <= IN_AB;
                                2'b10: begin
                                    state <= WAIT_CLEAR; fault_pulse <= 1'b1; gate_open <= 1'b0;
                                end
                                default: ;
                            endcase
                            OUT_B: case (ab)
                                2'b11: state <= OUT_AB;
                                2'b00: begin state <= IDLE; gate_open <= 1'b0; end
                                2'b10: begin
                                    state <= WAIT_CLEAR; fault_pulse <= 1'b1; gate_open <= 1'b0;
                                end
                                default: ;
                            endcase
                            OUT_AB: case (ab)
                                2'b10: state <= OUT_A;
                                2'b01: state <= OUT_B;
                                2'b00: begin state <= IDLE; gate_open <= 1'b0; end
                                default: ;
                            endcase
                            OUT_A: case (ab)
                                2'b00: begin
                                    state <= IDLE; exit_pulse <= 1'b1; gate_open <= 1'b0;
                                end
                                2'b11: state <= OUT_AB;
                                2'b01: begin
                                    state <= WAIT_CLEAR; fault_pulse <= 1'b1; gate_open <= 1'b0;
                                end
                                default: ;
                            endcase
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
